scaler_sfft_ctrl: RTL and testbench

Sequencer for the stochastic butterfly FFT array, driving its iClr, loadW and iEn controls through one transform.
On a start request it clears the array, loads twiddle weights, and streams for one full bitstream period plus pipeline latency.
It also counts the ones on each output lane, converting the stochastic output streams to binary.
Sits between the host/sequencing logic and one FFT instance; counts are held for readout until the next transform completes.

---
 rtl/scaler_sfft_ctrl.sv | 153 +++++++++++++++
 tb/tb_scaler_sfft_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/scaler_sfft_ctrl.sv
// Sequencer for the stochastic butterfly FFT: clear, load weights, stream N+LAT cycles,
// and count ones per output lane so the stochastic result can be read back as binary.
module scaler_sfft_ctrl #(
   parameter int BITWIDTH  = 8,
   parameter int NUMINPUTS = 8,
   parameter int LOG2N     = 3,
   parameter int LAT       = LOG2N
) (
   input  logic                                iClk,
   input  logic                                iRstN,
   input  logic                                iStart,
   input  logic                                iAbort,
   input  logic [NUMINPUTS-1:0]                iReal,
   input  logic [NUMINPUTS-1:0]                iImg,
   output logic                                oClr,
   output logic                                oLoadW,
   output logic                                oEn,
   output logic                                oBusy,
   output logic                                oDone,
   output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oRealCnt,
   output logic [NUMINPUTS*(BITWIDTH+1)-1:0]   oImgCnt
);

   localparam int N      = 1 << BITWIDTH;
   localparam int RUNLEN = N + LAT;
   localparam int CNTW   = $clog2(RUNLEN + 1);
   localparam int ACCW   = BITWIDTH + 1;
   localparam int VECW   = NUMINPUTS * ACCW;

   localparam logic [CNTW-1:0] LAST_CNT  = CNTW'(RUNLEN - 1);
   localparam logic [CNTW-1:0] FIRST_SMP = CNTW'(LAT);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      LOAD,
      RUN,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic [VECW-1:0]   accReal_q, accReal_d;
   logic [VECW-1:0]   accImg_q, accImg_d;
   logic [VECW-1:0]   realCnt_q, realCnt_d;
   logic [VECW-1:0]   imgCnt_q, imgCnt_d;
   logic              clr_q, clr_d;
   logic              loadW_q, loadW_d;
   logic              en_q, en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              sampleEn;
   logic              lastRun;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      accReal_d = accReal_q;
      accImg_d  = accImg_q;
      realCnt_d = realCnt_q;
      imgCnt_d  = imgCnt_q;
      sampleEn  = (state_q == RUN) && (cnt_q >= FIRST_SMP);
      lastRun   = (state_q == RUN) && (cnt_q == LAST_CNT);

      // The first LAT run cycles are pipeline fill; only later bits are counted.
      if (sampleEn) begin
         for (int k = 0; k < NUMINPUTS; k++) begin
            accReal_d[k*ACCW +: ACCW] = accReal_q[k*ACCW +: ACCW] + ACCW'(iReal[k]);
            accImg_d[k*ACCW +: ACCW]  = accImg_q[k*ACCW +: ACCW] + ACCW'(iImg[k]);
         end
      end

      unique case (state_q)
         IDLE: begin
            if (iStart && !iAbort) state_d = CLEAR;
         end
         CLEAR: begin
            state_d   = LOAD;
            cnt_d     = '0;
            accReal_d = '0;
            accImg_d  = '0;
         end
         LOAD: begin
            state_d = RUN;
         end
         RUN: begin
            if (lastRun) begin
               state_d   = DONE;
               realCnt_d = accReal_d;
               imgCnt_d  = accImg_d;
            end else begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // An abort discards the transform in progress, so readout keeps the last result.
      if (iAbort && (state_q != IDLE)) begin
         state_d   = IDLE;
         realCnt_d = realCnt_q;
         imgCnt_d  = imgCnt_q;
      end

      clr_d   = (state_d == CLEAR);
      loadW_d = (state_d == LOAD);
      en_d    = (state_d == RUN);
      busy_d  = (state_d != IDLE);
      done_d  = (state_d == DONE);
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         accReal_q <= '0;
         accImg_q  <= '0;
         realCnt_q <= '0;
         imgCnt_q  <= '0;
         clr_q     <= 1'b0;
         loadW_q   <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         accReal_q <= accReal_d;
         accImg_q  <= accImg_d;
         realCnt_q <= realCnt_d;
         imgCnt_q  <= imgCnt_d;
         clr_q     <= clr_d;
         loadW_q   <= loadW_d;
         en_q      <= en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign oClr     = clr_q;
   assign oLoadW   = loadW_q;
   assign oEn      = en_q;
   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oRealCnt = realCnt_q;
   assign oImgCnt  = imgCnt_q;

endmodule

// File: tb/tb_scaler_sfft_ctrl.sv
// Randomized scoreboard bench for scaler_sfft_ctrl with N=16, 8 lanes, LAT=3.
module tb_scaler_sfft_ctrl;

   localparam int BW      = 4;
   localparam int NI      = 8;
   localparam int LAT     = 3;
   localparam int N       = 1 << BW;
   localparam int ACCW    = BW + 1;
   localparam int RUNLEN  = N + LAT;
   localparam int PH_RUN0 = 3;
   localparam int PH_RUNZ = RUNLEN + 2;
   localparam int PH_DONE = RUNLEN + 3;

   logic                 iClk   = 1'b0;
   logic                 iRstN  = 1'b1;
   logic                 iStart = 1'b0;
   logic                 iAbort = 1'b0;
   logic [NI-1:0]        iReal  = '0;
   logic [NI-1:0]        iImg   = '0;
   logic                 oClr, oLoadW, oEn, oBusy, oDone;
   logic [NI*ACCW-1:0]   oRealCnt, oImgCnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [NI*ACCW-1:0] r;
      logic [NI*ACCW-1:0] i;
   } exp_t;

   exp_t               sbQ[$];
   int                 phase = 0;
   int                 accR[NI];
   int                 accI[NI];
   logic [NI*ACCW-1:0] heldR = '0;
   logic [NI*ACCW-1:0] heldI = '0;

   scaler_sfft_ctrl #(
      .BITWIDTH(BW),
      .NUMINPUTS(NI),
      .LOG2N(3),
      .LAT(LAT)
   ) dut (
      .iClk(iClk),
      .iRstN(iRstN),
      .iStart(iStart),
      .iAbort(iAbort),
      .iReal(iReal),
      .iImg(iImg),
      .oClr(oClr),
      .oLoadW(oLoadW),
      .oEn(oEn),
      .oBusy(oBusy),
      .oDone(oDone),
      .oRealCnt(oRealCnt),
      .oImgCnt(oImgCnt)
   );

   always #5 iClk = ~iClk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Reference model: phase is the number of cycles since the accepted start (0 = idle).
   always @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         phase = 0;
         heldR = '0;
         heldI = '0;
         sbQ.delete();
         for (int k = 0; k < NI; k++) begin
            accR[k] = 0;
            accI[k] = 0;
         end
      end else begin
         if (phase >= PH_RUN0 + LAT && phase <= PH_RUNZ) begin
            for (int k = 0; k < NI; k++) begin
               accR[k] += int'(iReal[k]);
               accI[k] += int'(iImg[k]);
            end
         end
         if (phase != 0 && iAbort) begin
            phase = 0;
         end else if (phase == 0) begin
            if (iStart && !iAbort) begin
               phase = 1;
               for (int k = 0; k < NI; k++) begin
                  accR[k] = 0;
                  accI[k] = 0;
               end
            end
         end else if (phase == PH_DONE) begin
            phase = 0;
         end else begin
            phase++;
            if (phase == PH_DONE) begin
               exp_t e;
               for (int k = 0; k < NI; k++) begin
                  e.r[k*ACCW +: ACCW] = ACCW'(accR[k]);
                  e.i[k*ACCW +: ACCW] = ACCW'(accI[k]);
               end
               sbQ.push_back(e);
               heldR = e.r;
               heldI = e.i;
            end
         end
      end
   end

   // Monitor: control timing every cycle, counts popped from the scoreboard on oDone.
   always @(negedge iClk) begin
      logic [4:0] expCtrl;
      expCtrl = {phase == 1, phase == 2, (phase >= PH_RUN0 && phase <= PH_RUNZ),
                 phase != 0, phase == PH_DONE};
      checkOutput("ctrl{clr,loadW,en,busy,done}", {59'd0, oClr, oLoadW, oEn, oBusy, oDone},
                  {59'd0, expCtrl});
      if (oDone) begin
         checkOutput("sb_expected_present", 64'(sbQ.size() != 0), 64'd1);
         if (sbQ.size() != 0) begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("done_realCnt", 64'(oRealCnt), 64'(e.r));
            checkOutput("done_imgCnt", 64'(oImgCnt), 64'(e.i));
         end
      end
      checkOutput("held_realCnt", 64'(oRealCnt), 64'(heldR));
      checkOutput("held_imgCnt", 64'(oImgCnt), 64'(heldI));
   end

   // mode 0: real all ones, imag all zeros; mode 1: lane-0 pattern with pre-sample ones; mode 2: random
   task automatic applyStimulus(input int mode, input int abortAt);
      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      for (int d = 1; d <= PH_DONE + 1; d++) begin
         int j;
         j = d - PH_RUN0;
         case (mode)
            0: begin
               iReal = '1;
               iImg  = '0;
            end
            1: begin
               iReal = NI'($urandom);
               iImg  = NI'($urandom);
               if (j >= 0 && j < LAT)           iReal[0] = 1'b1;
               else if (j >= LAT && j < RUNLEN) iReal[0] = ((j - LAT) % 2) == 0;
               else                             iReal[0] = 1'b0;
            end
            default: begin
               iReal = NI'($urandom);
               iImg  = NI'($urandom);
            end
         endcase
         iAbort = (abortAt >= 0) && (j == abortAt);
         tick();
      end
      iAbort = 1'b0;
   endtask

   initial begin
      #2 iRstN = 1'b0;
      repeat (3) tick();
      iRstN = 1'b1;
      repeat (3) tick();

      applyStimulus(0, -1);
      applyStimulus(1, -1);
      applyStimulus(2, -1);
      applyStimulus(2, 5);
      repeat (3) tick();

      iStart = 1'b1;
      repeat (2 * (PH_DONE + 1) + 5) begin
         iReal = NI'($urandom);
         iImg  = NI'($urandom);
         tick();
      end
      iStart = 1'b0;
      repeat (PH_DONE + 5) begin
         iReal = NI'($urandom);
         iImg  = NI'($urandom);
         tick();
      end

      iStart = 1'b1;
      iAbort = 1'b1;
      repeat (4) tick();
      iStart = 1'b0;
      iAbort = 1'b0;
      tick();

      iStart = 1'b1;
      tick();
      iStart = 1'b0;
      repeat (10) begin
         iReal = NI'($urandom);
         iImg  = NI'($urandom);
         tick();
      end
      #2 iRstN = 1'b0;
      #1;
      checkOutput("async_rst_en", 64'(oEn), 64'd0);
      checkOutput("async_rst_busy", 64'(oBusy), 64'd0);
      checkOutput("async_rst_realCnt", 64'(oRealCnt), 64'd0);
      checkOutput("async_rst_imgCnt", 64'(oImgCnt), 64'd0);
      #3 iRstN = 1'b1;
      repeat (2) tick();
      applyStimulus(2, -1);
      applyStimulus(0, -1);

      for (int w = 0; w < 100 && sbQ.size() != 0; w++) tick();
      checkOutput("sb_drained", 64'(sbQ.size()), 64'd0);
      repeat (2) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
